// File: rtl/clk_period_monitor_pkg.sv
// Shared definitions for the clock period monitor and the divider status logic.
package clk_period_monitor_pkg;

  localparam int CNT_W_DEF = 24;

  localparam logic [1:0] WAIT_FIRST = 2'd0;
  localparam logic [1:0] MEASURE    = 2'd1;
  localparam logic [1:0] LOST       = 2'd2;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser with rising-edge detect, masked until 3 cycles after reset
// so an input already high at reset release never looks like an edge.
module sync_rise_detect (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic       s1, s2, s3;
  logic [1:0] arm_cnt;
  logic       armed;

  assign armed = (arm_cnt == 2'd3);
  assign rise  = s2 & ~s3 & armed;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      arm_cnt <= 2'd0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/clk_period_monitor.sv
// Measures the period of a slow asynchronous clock in clk_in cycles, checks it
// against an expected window and flags loss of clock.
module clk_period_monitor
  import clk_period_monitor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int EXP_PERIOD  = 4_999_682,
  parameter int TOL         = 64,
  parameter int TIMEOUT_CYC = 6_000_000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clk_mon,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             in_range,
  output logic             lost,
  output logic [15:0]      meas_cnt
);

  // Lower bound clamps at zero when TOL exceeds the expected period.
  localparam int               LO_I = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
  localparam logic [CNT_W:0]   LO_B = (CNT_W+1)'(LO_I);
  localparam logic [CNT_W:0]   HI_B = (CNT_W+1)'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TO_B = CNT_W'(TIMEOUT_CYC);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             rise;
  logic             in_win;

  sync_rise_detect u_rise (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_in (clk_mon),
    .rise     (rise)
  );

  assign cnt_inc = cnt + CNT_W'(1);
  assign in_win  = ({1'b0, cnt_inc} >= LO_B) && ({1'b0, cnt_inc} <= HI_B);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= WAIT_FIRST;
      cnt        <= '0;
      period_out <= '0;
      valid      <= 1'b0;
      in_range   <= 1'b0;
      lost       <= 1'b0;
      meas_cnt   <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        WAIT_FIRST: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= '0;
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle is still a valid measurement.
          if (rise) begin
            period_out <= cnt_inc;
            in_range   <= in_win;
            valid      <= 1'b1;
            meas_cnt   <= meas_cnt + 16'd1;
            cnt        <= '0;
          end else if (cnt_inc == TO_B) begin
            state <= LOST;
            lost  <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LOST: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= '0;
            lost  <= 1'b0;
          end
        end
        default: state <= WAIT_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor with EXP_PERIOD=100, TOL=2, TIMEOUT_CYC=150.
module tb_clk_period_monitor;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        clk_mon = 1'b0;
  logic [23:0] period_out;
  logic        valid;
  logic        in_range;
  logic        lost;
  logic [15:0] meas_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] period;
    logic        inr;
    logic [15:0] mc;
  } vrec_t;

  vrec_t vq[$];
  logic  lost_seen = 1'b0;

  clk_period_monitor #(
    .CNT_W       (24),
    .EXP_PERIOD  (100),
    .TOL         (2),
    .TIMEOUT_CYC (150)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .clk_mon    (clk_mon),
    .period_out (period_out),
    .valid      (valid),
    .in_range   (in_range),
    .lost       (lost),
    .meas_cnt   (meas_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Record every valid pulse, sampled on the falling edge.
  always @(negedge clk_in) begin
    if (valid === 1'b1) vq.push_back('{period_out, in_range, meas_cnt});
    if (lost === 1'b1) lost_seen = 1'b1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Rise now, fall halfway, return exactly p cycles after the rise.
  task automatic rtw(input int p);
    clk_mon = 1'b1;
    wait_cyc(p / 2);
    clk_mon = 1'b0;
    wait_cyc(p - p / 2);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    clk_mon = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(5);
    vq.delete();
    lost_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_mon = 1'b0;
    wait_cyc(3);
    checks++;
    if ({period_out, valid, in_range, lost, meas_cnt} !== 43'd0) begin
      errors++;
      $display("FAIL reset_outputs: got p=%0d v=%b r=%b l=%b m=%0d, need all 0",
               period_out, valid, in_range, lost, meas_cnt);
    end
    rst_n = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_nominal();
    do_reset();
    rtw(100);
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL nominal_first_rise: got %0d valids, need 0", vq.size());
    end
    rtw(100);
    rtw(100);
    clk_mon = 1'b1;
    wait_cyc(6);
    checks++;
    if (vq.size() != 3) begin
      errors++;
      $display("FAIL nominal_count: got %0d valids, need 3", vq.size());
    end
    for (int i = 0; i < 3 && i < vq.size(); i++) begin
      checks++;
      if (vq[i].period !== 24'd100 || vq[i].inr !== 1'b1 || vq[i].mc !== 16'(i + 1)) begin
        errors++;
        $display("FAIL nominal_meas%0d: got p=%0d r=%b m=%0d, need p=100 r=1 m=%0d",
                 i, vq[i].period, vq[i].inr, vq[i].mc, i + 1);
      end
    end
    checks++;
    if (period_out !== 24'd100 || in_range !== 1'b1 || lost !== 1'b0) begin
      errors++;
      $display("FAIL nominal_hold: got p=%0d r=%b l=%b, need p=100 r=1 l=0",
               period_out, in_range, lost);
    end
  endtask

  task automatic test_range();
    int          gaps[3] = '{102, 103, 97};
    logic        exp_r[3] = '{1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) rtw(gaps[i]);
    clk_mon = 1'b1;
    wait_cyc(6);
    checks++;
    if (vq.size() != 3) begin
      errors++;
      $display("FAIL range_count: got %0d valids, need 3", vq.size());
    end
    for (int i = 0; i < 3 && i < vq.size(); i++) begin
      checks++;
      if (vq[i].period !== 24'(gaps[i]) || vq[i].inr !== exp_r[i]) begin
        errors++;
        $display("FAIL range_p%0d: got p=%0d r=%b, need p=%0d r=%b",
                 gaps[i], vq[i].period, vq[i].inr, gaps[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_lost();
    int first = 0;
    do_reset();
    rtw(100);
    clk_mon = 1'b1;
    // Rise reaches the FSM 3 edges after clk_mon, then 150 counted cycles.
    for (int i = 1; i <= 170; i++) begin
      wait_cyc(1);
      if (lost === 1'b1 && first == 0) first = i;
    end
    checks++;
    if (first != 153) begin
      errors++;
      $display("FAIL lost_timing: got lost at edge %0d, need 153", first);
    end
    checks++;
    if (period_out !== 24'd100 || meas_cnt !== 16'd1 || vq.size() != 1) begin
      errors++;
      $display("FAIL lost_hold: got p=%0d m=%0d n=%0d, need p=100 m=1 n=1",
               period_out, meas_cnt, vq.size());
    end
    clk_mon = 1'b0;
    wait_cyc(5);
    clk_mon = 1'b1;
    wait_cyc(5);
    checks++;
    if (lost !== 1'b0 || vq.size() != 1) begin
      errors++;
      $display("FAIL lost_resume: got l=%b n=%0d, need l=0 n=1", lost, vq.size());
    end
    wait_cyc(45);
    clk_mon = 1'b0;
    wait_cyc(50);
    clk_mon = 1'b1;
    wait_cyc(6);
    checks++;
    if (vq.size() != 2 || period_out !== 24'd100 || meas_cnt !== 16'd2) begin
      errors++;
      $display("FAIL lost_second_rise: got n=%0d p=%0d m=%0d, need n=2 p=100 m=2",
               vq.size(), period_out, meas_cnt);
    end
  endtask

  task automatic test_high_through_reset();
    rst_n   = 1'b0;
    clk_mon = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    vq.delete();
    wait_cyc(20);
    checks++;
    if (vq.size() != 0 || period_out !== 24'd0 || lost !== 1'b0) begin
      errors++;
      $display("FAIL high_reset_no_rise: got n=%0d p=%0d l=%b, need n=0 p=0 l=0",
               vq.size(), period_out, lost);
    end
    clk_mon = 1'b0;
    wait_cyc(10);
    rtw(100);
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL high_reset_first_genuine: got %0d valids, need 0", vq.size());
    end
    clk_mon = 1'b1;
    wait_cyc(6);
    checks++;
    if (vq.size() != 1 || period_out !== 24'd100 || meas_cnt !== 16'd1) begin
      errors++;
      $display("FAIL high_reset_second_genuine: got n=%0d p=%0d m=%0d, need n=1 p=100 m=1",
               vq.size(), period_out, meas_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    rtw(100);
    clk_mon = 1'b1;
    wait_cyc(40);
    checks++;
    if (meas_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mid_reset_setup: got m=%0d, need 1", meas_cnt);
    end
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    checks++;
    if ({period_out, valid, in_range, lost, meas_cnt} !== 43'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got p=%0d v=%b r=%b l=%b m=%0d, need all 0",
               period_out, valid, in_range, lost, meas_cnt);
    end
    clk_mon = 1'b0;
    wait_cyc(5);
    vq.delete();
    rtw(100);
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_wait_first: got %0d valids, need 0", vq.size());
    end
    clk_mon = 1'b1;
    wait_cyc(6);
    checks++;
    if (vq.size() != 1 || period_out !== 24'd100 || meas_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mid_reset_remeasure: got n=%0d p=%0d m=%0d, need n=1 p=100 m=1",
               vq.size(), period_out, meas_cnt);
    end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    rtw(150);
    clk_mon = 1'b1;
    wait_cyc(6);
    checks++;
    if (vq.size() != 1 || period_out !== 24'd150 || in_range !== 1'b0) begin
      errors++;
      $display("FAIL boundary_valid: got n=%0d p=%0d r=%b, need n=1 p=150 r=0",
               vq.size(), period_out, in_range);
    end
    checks++;
    if (lost_seen !== 1'b0 || lost !== 1'b0) begin
      errors++;
      $display("FAIL boundary_lost: got seen=%b l=%b, need 0 0", lost_seen, lost);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_range();
    test_lost();
    test_high_through_reset();
    test_mid_reset();
    test_timeout_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
